// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU (A) and
// load (B) writeback requesters with round-robin arbitration. It also keeps
// a pending-write scoreboard that decode uses for RAW/WAW hazard checks.
// Register 0 is hardwired zero: it is never written and never pending.
module rf_wb_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_wr,
  input  logic [DW-1:0] a_wd,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_wr,
  input  logic [DW-1:0] b_wd,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wr,
  output logic          iss_ready,
  input  logic [AW-1:0] q_pr1,
  input  logic [AW-1:0] q_pr2,
  output logic          busy1,
  output logic          busy2,
  output logic          rf_write,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd
);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_t;

  grant_t          last_grant_q, last_grant_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            rf_write_q, rf_write_d;
  logic [AW-1:0]   rf_wr_q, rf_wr_d;
  logic [DW-1:0]   rf_wd_q, rf_wd_d;
  logic            hs;
  logic [AW-1:0]   sel_wr;
  logic [DW-1:0]   sel_wd;

  // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    a_ready = a_valid & (~b_valid | (last_grant_q == GNT_B));
    b_ready = b_valid & (~a_valid | (last_grant_q == GNT_A));
  end

  // Pick the winner's write and compute next write-port and grant-pointer state.
  always_comb begin
    hs           = a_ready | b_ready;
    sel_wr       = a_ready ? a_wr : b_wr;
    sel_wd       = a_ready ? a_wd : b_wd;
    last_grant_d = last_grant_q;
    if (a_ready)      last_grant_d = GNT_A;
    else if (b_ready) last_grant_d = GNT_B;
    // A handshake to r0 completes but produces no register-file write.
    rf_write_d = hs & (sel_wr != '0);
    rf_wr_d    = rf_wr_q;
    rf_wd_d    = rf_wd_q;
    if (rf_write_d) begin
      rf_wr_d = sel_wr;
      rf_wd_d = sel_wd;
    end
  end

  // Issue gating and hazard queries read the scoreboard directly, with no bypass.
  always_comb begin
    iss_ready = ~pending_q[iss_wr] | (iss_wr == '0);
    busy1     = pending_q[q_pr1];
    busy2     = pending_q[q_pr2];
  end

  // Scoreboard update: the retiring write clears first, so a same-edge issue set wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_write_q) pending_d[rf_wr_q] = 1'b0;
    if (iss_valid && iss_ready && (iss_wr != '0)) pending_d[iss_wr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight write and gives A the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GNT_B;
      pending_q    <= '0;
      rf_write_q   <= 1'b0;
      rf_wr_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      rf_write_q   <= rf_write_d;
      rf_wr_q      <= rf_wr_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  // Register-file write interface is driven straight from flops.
  always_comb begin
    rf_write = rf_write_q;
    rf_wr    = rf_wr_q;
    rf_wd    = rf_wd_q;
  end

endmodule
